// File: rtl/plan_act_pipe_if.sv
// plan_act_pipe_if: valid/ready stream bundle for the PLAN activation unit.
// Upstream sample channel and downstream result channel share one interface.
interface plan_act_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_x, in_mode, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, in_mode, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/plan_act_pipe.sv
// plan_act_pipe: 3-stage shift-add PLAN sigmoid with valid/ready streaming.
// Define PLAN_TANH_EN to add the tanh mode selected by in_mode.
module plan_act_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  plan_act_pipe_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] HALF  = WIDTH'(1) << (FRAC - 1);
  localparam logic [WIDTH-1:0] FIVE  = WIDTH'(5) << FRAC;
  localparam logic [WIDTH-1:0] BP_HI = WIDTH'(19) << (FRAC - 3);
  localparam logic [WIDTH-1:0] C_HI  = WIDTH'(27) << (FRAC - 5);
  localparam logic [WIDTH-1:0] C_MID = WIDTH'(5) << (FRAC - 3);
  localparam logic [WIDTH-1:0] MAXP  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    SEG_SAT,
    SEG_HI,
    SEG_MID,
    SEG_LO
  } seg_e;

  typedef struct packed {
    logic             vld;
    logic             neg;
`ifdef PLAN_TANH_EN
    logic             mode;
`endif
    seg_e             seg;
    logic [WIDTH-1:0] a;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             neg;
`ifdef PLAN_TANH_EN
    logic             mode;
`endif
    logic [WIDTH-1:0] m;
  } s2_t;

  logic             en;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             vld3;
  logic [WIDTH-1:0] y_d, y_q;
  logic [WIDTH-1:0] x_abs;

  assign en            = !vld3 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld3;
  assign bus.out_y     = y_q;

`ifndef PLAN_TANH_EN
  logic unused_mode;
  assign unused_mode = bus.in_mode;
`endif

  // S1: magnitude with saturation, then segment select
  always_comb begin
    s1_d     = '0;
    s1_d.vld = bus.in_valid;
    s1_d.neg = bus.in_x[WIDTH-1];
    x_abs    = bus.in_x;
    if (bus.in_x == MINV)
      x_abs = MAXP;
    else if (bus.in_x[WIDTH-1])
      x_abs = -bus.in_x;
    s1_d.a = x_abs;
`ifdef PLAN_TANH_EN
    s1_d.mode = bus.in_mode;
    if (bus.in_mode)
      s1_d.a = (x_abs > (MAXP >> 1)) ? MAXP : (x_abs << 1);
`endif
    if (s1_d.a >= FIVE)
      s1_d.seg = SEG_SAT;
    else if (s1_d.a >= BP_HI)
      s1_d.seg = SEG_HI;
    else if (s1_d.a >= ONE)
      s1_d.seg = SEG_MID;
    else
      s1_d.seg = SEG_LO;
  end

  always_comb begin
    s2_d     = '0;
    s2_d.vld = s1_q.vld;
    s2_d.neg = s1_q.neg;
`ifdef PLAN_TANH_EN
    s2_d.mode = s1_q.mode;
`endif
    unique case (s1_q.seg)
      SEG_SAT: s2_d.m = ONE;
      SEG_HI:  s2_d.m = (s1_q.a >> 5) + C_HI;
      SEG_MID: s2_d.m = (s1_q.a >> 3) + C_MID;
      SEG_LO:  s2_d.m = (s1_q.a >> 2) + HALF;
    endcase
  end

`ifdef PLAN_TANH_EN
  logic [WIDTH-1:0] t;
  assign t = (s2_q.m << 1) - ONE;
`endif

  // S3: sigmoid symmetry 1-m; tanh is odd around 0
  always_comb begin
    y_d = s2_q.neg ? (ONE - s2_q.m) : s2_q.m;
`ifdef PLAN_TANH_EN
    if (s2_q.mode)
      y_d = s2_q.neg ? -t : t;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      vld3 <= 1'b0;
      y_q  <= '0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      vld3 <= s2_q.vld;
      y_q  <= y_d;
    end
  end

endmodule

// File: tb/tb_plan_act_pipe.sv
// tb_plan_act_pipe: directed-vector bench for the PLAN activation pipeline.
// Each scenario task drives its vectors and checks inline.
module tb_plan_act_pipe;

  logic clk;
  logic rst_n;

  plan_act_pipe_if #(.WIDTH(16)) bus ();

  plan_act_pipe #(.WIDTH(16), .FRAC(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] xs[16];
  logic        md[16];
  logic [15:0] got[$];
  int          gc[$];
  int          stall_seen;
  int          hold_err;

  task automatic run(input int n, input int st, input int sl,
                     input int cycles);
    int          i;
    logic        held;
    logic [15:0] yh;
    i = 0;
    held = 1'b0;
    yh = '0;
    got.delete();
    gc.delete();
    stall_seen = 0;
    hold_err = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.in_valid  = (i < n);
      bus.in_x      = (i < n) ? xs[i] : 16'h0000;
      bus.in_mode   = (i < n) ? md[i] : 1'b0;
      bus.out_ready = !(c >= st && c < st + sl);
      #1;
      if (!bus.in_ready) stall_seen++;
      if (held && bus.out_y !== yh) hold_err++;
      held = bus.out_valid && !bus.out_ready;
      yh = bus.out_y;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_y);
        gc.push_back(c);
      end
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_y !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_out_y got %h want 0000", bus.out_y);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single;
    xs[0] = 16'h0000;
    md[0] = 1'b0;
    run(1, 99, 0, 8);
    n_cmp++;
    if (got.size() !== 1) begin
      n_err++;
      $display("FAIL single_count got %0d want 1", got.size());
    end
    n_cmp++;
    if ((got.size() > 0 ? got[0] : 16'hxxxx) !== 16'h0800) begin
      n_err++;
      $display("FAIL single_y got %h want 0800",
               got.size() > 0 ? got[0] : 16'hxxxx);
    end
    n_cmp++;
    if ((gc.size() > 0 ? gc[0] : -1) !== 3) begin
      n_err++;
      $display("FAIL single_latency got %0d want 3",
               gc.size() > 0 ? gc[0] : -1);
    end
    n_cmp++;
    if (stall_seen !== 0) begin
      n_err++;
      $display("FAIL single_in_ready low cycles %0d want 0", stall_seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e[5];
    xs[0:4] = '{16'h1000, 16'h2000, 16'hE000, 16'h3000, 16'h6000};
    e = '{16'h0C00, 16'h0E00, 16'h0200, 16'h0F00, 16'h1000};
    for (int k = 0; k < 5; k++) md[k] = 1'b0;
    run(5, 99, 0, 14);
    n_cmp++;
    if (got.size() !== 5) begin
      n_err++;
      $display("FAIL b2b_count got %0d want 5", got.size());
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ((k < got.size() ? got[k] : 16'hxxxx) !== e[k]) begin
        n_err++;
        $display("FAIL b2b_y[%0d] got %h want %h", k,
                 k < got.size() ? got[k] : 16'hxxxx, e[k]);
      end
      n_cmp++;
      if ((k < gc.size() ? gc[k] : -1) !== 3 + k) begin
        n_err++;
        $display("FAIL b2b_cycle[%0d] got %0d want %0d", k,
                 k < gc.size() ? gc[k] : -1, 3 + k);
      end
    end
  endtask

  task automatic test_stall;
    logic [15:0] e[6];
    xs[0:5] = '{16'h0000, 16'h1000, 16'hF000, 16'h2000, 16'h3000,
                16'h6000};
    e = '{16'h0800, 16'h0C00, 16'h0400, 16'h0E00, 16'h0F00, 16'h1000};
    for (int k = 0; k < 6; k++) md[k] = 1'b0;
    run(6, 2, 4, 25);
    n_cmp++;
    if (got.size() !== 6) begin
      n_err++;
      $display("FAIL stall_count got %0d want 6", got.size());
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if ((k < got.size() ? got[k] : 16'hxxxx) !== e[k]) begin
        n_err++;
        $display("FAIL stall_y[%0d] got %h want %h", k,
                 k < got.size() ? got[k] : 16'hxxxx, e[k]);
      end
    end
    n_cmp++;
    if (stall_seen < 1) begin
      n_err++;
      $display("FAIL stall_in_ready low cycles %0d want >=1", stall_seen);
    end
    n_cmp++;
    if (hold_err !== 0) begin
      n_err++;
      $display("FAIL stall_hold changes %0d want 0", hold_err);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] e[7];
    xs[0:6] = '{16'h5000, 16'h2600, 16'h8000, 16'h4FFF, 16'h25FF,
                16'h0FFF, 16'h7FFF};
    e = '{16'h1000, 16'h0EB0, 16'h0000, 16'h0FFF, 16'h0EBF,
          16'h0BFF, 16'h1000};
    for (int k = 0; k < 7; k++) md[k] = 1'b0;
    run(7, 99, 0, 16);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if ((k < got.size() ? got[k] : 16'hxxxx) !== e[k]) begin
        n_err++;
        $display("FAIL bound_y[%0d] x=%h got %h want %h", k, xs[k],
                 k < got.size() ? got[k] : 16'hxxxx, e[k]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    xs[0:2] = '{16'h1000, 16'h2000, 16'h3000};
    for (int k = 0; k < 3; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = xs[k];
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== 16'h0C00) begin
      n_err++;
      $display("FAIL midrst_pre got v=%b y=%h want v=1 y=0C00",
               bus.out_valid, bus.out_y);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_out_valid got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_y !== 16'h0000) begin
      n_err++;
      $display("FAIL midrst_out_y got %h want 0000", bus.out_y);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    xs[0] = 16'h3000;
    md[0] = 1'b0;
    run(1, 99, 0, 8);
    n_cmp++;
    if (got.size() !== 1) begin
      n_err++;
      $display("FAIL midrst_count got %0d want 1", got.size());
    end
    n_cmp++;
    if ((got.size() > 0 ? got[0] : 16'hxxxx) !== 16'h0F00) begin
      n_err++;
      $display("FAIL midrst_y got %h want 0F00",
               got.size() > 0 ? got[0] : 16'hxxxx);
    end
    n_cmp++;
    if ((gc.size() > 0 ? gc[0] : -1) !== 3) begin
      n_err++;
      $display("FAIL midrst_latency got %0d want 3",
               gc.size() > 0 ? gc[0] : -1);
    end
  endtask

  task automatic test_mode;
    logic [15:0] e[4];
    xs[0:3] = '{16'h1000, 16'hF000, 16'h0000, 16'h1000};
    md[0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef PLAN_TANH_EN
    e = '{16'h0C00, 16'hF400, 16'h0000, 16'h0C00};
`else
    e = '{16'h0C00, 16'h0400, 16'h0800, 16'h0C00};
`endif
    run(4, 99, 0, 12);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ((k < got.size() ? got[k] : 16'hxxxx) !== e[k]) begin
        n_err++;
        $display("FAIL mode_y[%0d] x=%h mode=%b got %h want %h", k, xs[k],
                 md[k], k < got.size() ? got[k] : 16'hxxxx, e[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_boundaries();
    test_reset_midstream();
    test_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
